// File: rtl/checksum_pkg.sv
// Shared constants and types for the streaming checksum checker.
package checksum_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_KEY = 8'b00110111;

  typedef enum logic {
    RECV = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/checksum_stream_if.sv
// Beat input and verdict output bundle of checksum_stream.
interface checksum_stream_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic              res_ok;
  logic              res_ovf;
  logic [LEN_W-1:0]  res_len;
  logic [CNT_W-1:0]  cnt_ok;
  logic [CNT_W-1:0]  cnt_bad;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_ok, res_ovf, res_len, cnt_ok, cnt_bad
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_ok, res_ovf, res_len, cnt_ok, cnt_bad
  );
endinterface

// File: rtl/checksum_cmp.sv
// Combinational check-word compare: data must equal the accumulated XOR keyed by KEY.
module checksum_cmp #(
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] KEY    = DATA_W'(8'b00110111)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] acc,
  output logic              match_c
);

  assign match_c = (data == (acc ^ KEY));

endmodule

// File: rtl/checksum_stream.sv
// Frame checksum checker: XOR-accumulates payload beats, judges the closing
// check word, holds the verdict until consumed and keeps pass/fail totals.
module checksum_stream
  import checksum_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] KEY     = DATA_W'(DEFAULT_KEY),
  parameter int unsigned       MAX_LEN = 16,
  parameter int unsigned       CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  checksum_stream_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  acc;
  logic [LEN_W-1:0]   len;
  logic               ovf;
  logic               res_ok;
  logic               res_ovf;
  logic [LEN_W-1:0]   res_len;
  logic [CNT_W-1:0]   cnt_ok;
  logic [CNT_W-1:0]   cnt_bad;
  logic               accept_c;
  logic               release_c;
  logic               match_c;

  checksum_cmp #(
    .DATA_W (DATA_W),
    .KEY    (KEY)
  ) u_cmp (
    .data    (bus.in_data),
    .acc     (acc),
    .match_c (match_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RECV;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the accept/release strobes that steer the datapath.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    release_c = 1'b0;
    unique case (state)
      RECV: begin
        accept_c = bus.in_valid;
        if (bus.in_valid && bus.in_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        release_c = bus.res_ready;
        if (bus.res_ready) begin
          state_nxt = RECV;
        end
      end
      default: state_nxt = RECV;
    endcase
  end

  // Frame accumulator, length and overflow tracking, verdict capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      len     <= '0;
      ovf     <= 1'b0;
      res_ok  <= 1'b0;
      res_ovf <= 1'b0;
      res_len <= '0;
    end else if (accept_c) begin
      if (!bus.in_last) begin
        acc <= acc ^ bus.in_data;
        if (len == LEN_W'(MAX_LEN)) begin
          ovf <= 1'b1;
        end else begin
          len <= len + LEN_W'(1);
        end
      end else begin
        // An empty frame never passes, even when the check word equals KEY.
        res_ok  <= match_c && (len != '0) && !ovf;
        res_ovf <= ovf;
        res_len <= len;
      end
    end else if (release_c) begin
      acc <= '0;
      len <= '0;
      ovf <= 1'b0;
    end
  end

  // Saturating frame statistics, bumped once per consumed verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok  <= '0;
      cnt_bad <= '0;
    end else if (release_c) begin
      if (res_ok) begin
        if (cnt_ok != '1) begin
          cnt_ok <= cnt_ok + CNT_W'(1);
        end
      end else if (cnt_bad != '1) begin
        cnt_bad <= cnt_bad + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state == RECV);
  assign bus.res_valid = (state == DONE);
  assign bus.res_ok    = res_ok;
  assign bus.res_ovf   = res_ovf;
  assign bus.res_len   = res_len;
  assign bus.cnt_ok    = cnt_ok;
  assign bus.cnt_bad   = cnt_bad;

endmodule

// File: tb/tb_checksum_stream.sv
// Bench for checksum_stream: frame-level reference model, per-cycle compare,
// directed frames with literal expectations, then randomized traffic.
module tb_checksum_stream;

  localparam int unsigned DATA_W  = 8;
  localparam logic [7:0]  KEY     = 8'h37;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  checksum_stream_if #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) bus ();

  checksum_stream #(
    .DATA_W  (DATA_W),
    .KEY     (KEY),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words of the open frame, pending verdict, totals.
  logic [7:0] m_q[$];
  bit         m_done = 1'b0;
  bit         m_ok   = 1'b0;
  bit         m_ovf  = 1'b0;
  int         m_len  = 0;
  int         m_cnt_ok  = 0;
  int         m_cnt_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_done = 1'b0;
      m_ok = 1'b0;
      m_ovf = 1'b0;
      m_len = 0;
      m_cnt_ok = 0;
      m_cnt_bad = 0;
    end else if (!m_done) begin
      if (bus.in_valid) begin
        if (!bus.in_last) begin
          m_q.push_back(bus.in_data);
        end else begin
          m_ovf  = (m_q.size() > MAX_LEN);
          m_len  = m_ovf ? MAX_LEN : m_q.size();
          m_ok   = (bus.in_data == (frame_xor() ^ KEY)) && (m_q.size() >= 1) && !m_ovf;
          m_done = 1'b1;
        end
      end
    end else if (bus.res_ready) begin
      if (m_ok) begin
        if (m_cnt_ok < CNT_MAX) m_cnt_ok++;
      end else if (m_cnt_bad < CNT_MAX) begin
        m_cnt_bad++;
      end
      m_q.delete();
      m_done = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("in_ready", int'(bus.in_ready), int'(!m_done));
    chk("res_valid", int'(bus.res_valid), int'(m_done));
    chk("cnt_ok", int'(bus.cnt_ok), m_cnt_ok);
    chk("cnt_bad", int'(bus.cnt_bad), m_cnt_bad);
    if (m_done) begin
      chk("res_ok", int'(bus.res_ok), int'(m_ok));
      chk("res_ovf", int'(bus.res_ovf), int'(m_ovf));
      chk("res_len", int'(bus.res_len), m_len);
    end
  end

  task automatic beat(input logic [7:0] d, input logic l);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.res_ready = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic ack();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic verdict(input string nm, input int ok, input int ovf, input int len);
    chk({nm, "_valid"}, int'(bus.res_valid), 1);
    chk({nm, "_ok"}, int'(bus.res_ok), ok);
    chk({nm, "_ovf"}, int'(bus.res_ovf), ovf);
    chk({nm, "_len"}, int'(bus.res_len), len);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    rst = 1'b0;

    // Single word frame: AA ^ 37 = 9D.
    beat(8'hAA, 1'b0);
    beat(8'h9D, 1'b1);
    settle();
    verdict("one_word", 1, 0, 1);
    ack();
    chk("one_word_cnt_ok", int'(bus.cnt_ok), 1);

    // AA ^ AD ^ AF = A8, A8 ^ 37 = 9F.
    beat(8'hAA, 1'b0); beat(8'hAD, 1'b0); beat(8'hAF, 1'b0);
    beat(8'h9F, 1'b1);
    settle();
    verdict("three_good", 1, 0, 3);
    chk("model_len_pin", m_len, 3);
    ack();
    beat(8'hAA, 1'b0); beat(8'hAD, 1'b0); beat(8'hAF, 1'b0);
    beat(8'h9E, 1'b1);
    settle();
    verdict("three_bad", 0, 0, 3);
    ack();
    chk("three_bad_cnt_bad", int'(bus.cnt_bad), 1);
    chk("model_cnt_ok_pin", m_cnt_ok, 2);

    // Lone check word equal to KEY still fails.
    beat(8'h37, 1'b1);
    settle();
    verdict("empty", 0, 0, 0);
    ack();

    // Five payload words overflow a 4-word limit.
    repeat (5) beat(8'h01, 1'b0);
    beat(8'h36, 1'b1);
    settle();
    verdict("overflow", 0, 1, 4);
    ack();
    chk("overflow_cnt_bad", int'(bus.cnt_bad), 3);

    // Backpressure: verdict held, beats ignored while unconsumed.
    beat(8'hAA, 1'b0);
    beat(8'h9D, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      verdict("bp_hold", 1, 0, 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    ack();
    chk("bp_release_ready", int'(bus.in_ready), 1);
    chk("bp_release_cnt_ok", int'(bus.cnt_ok), 3);

    // Mid-frame reset, colliding with a check-word beat, discards everything.
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_data = 8'h33;
    bus.in_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("rst_mid_ready", int'(bus.in_ready), 1);
    chk("rst_mid_cnt_ok", int'(bus.cnt_ok), 0);
    chk("rst_mid_cnt_bad", int'(bus.cnt_bad), 0);
    beat(8'hAA, 1'b0);
    beat(8'h9D, 1'b1);
    settle();
    verdict("after_rst", 1, 0, 1);
    ack();

    // Randomized traffic; long enough for the 4-bit totals to saturate.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 499) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.res_ready = ($urandom_range(0, 1) == 1);
      if (bus.in_last && $urandom_range(0, 1) == 1) begin
        bus.in_data = frame_xor() ^ KEY;
      end else begin
        bus.in_data = 8'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/checksum_stream.md
CHECKSUM_STREAM -- requirements
Module: checksum_stream

Interface
REQ-001 Parameter DATA_W, default 8: width of payload and check words.
REQ-002 Parameter KEY, default 8'b00110111 (sized DATA_W): checksum key.
REQ-003 Parameter MAX_LEN, default 16: maximum payload words per frame (>=1).
REQ-004 Parameter CNT_W, default 16: width of frame statistics counters.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  module accepts a beat.
REQ-009 in_data  in  DATA_W  payload word, or check word when in_last=1.
REQ-010 in_last  in  1  marks the check word, which closes the frame.
REQ-011 res_valid  out  1  frame verdict available.
REQ-012 res_ready  in  1  consumer accepts the verdict.
REQ-013 res_ok  out  1  frame passed all checks.
REQ-014 res_ovf  out  1  frame exceeded MAX_LEN payload words.
REQ-015 res_len  out  $clog2(MAX_LEN+1)  payload words counted, saturated at MAX_LEN.
REQ-016 cnt_ok, cnt_bad  out  CNT_W each  saturating passed/failed frame totals.

Function
REQ-017 A beat is accepted when in_valid and in_ready are high on the same rising clk edge; other cycles leave state unchanged.
REQ-018 The module SHALL have two states: RECV (in_ready=1, res_valid=0) and DONE (in_ready=0, res_valid=1).
REQ-019 In RECV, an accepted beat with in_last=0 SHALL set acc <= acc XOR in_data and increment len, saturating at MAX_LEN.
REQ-020 If a payload beat arrives while len==MAX_LEN, the sticky ovf flag SHALL set; acc still updates.
REQ-021 Expected check word = acc XOR KEY, where acc is the XOR of all payload words; an empty payload gives KEY.
REQ-022 In RECV, an accepted beat with in_last=1 SHALL register res_ok = (in_data == acc XOR KEY) AND len>=1 AND NOT ovf, latch res_ovf and res_len, and enter DONE the next cycle.
REQ-023 Verdict latency is one cycle: res_valid rises on the edge that accepts the check word.
REQ-024 In DONE, res_ok, res_ovf and res_len SHALL hold stable until the res_valid AND res_ready handshake completes.
REQ-025 On the handshake, the module SHALL return to RECV, clear acc, len and ovf, and increment cnt_ok if res_ok=1, else cnt_bad.
REQ-026 cnt_ok and cnt_bad SHALL stop at all-ones and not wrap.
REQ-027 Input beats presented while in DONE are not accepted (backpressure) and SHALL NOT affect acc or len.
REQ-028 A check word alone (len=0) SHALL give res_ok=0, even if in_data==KEY.

Reset
REQ-029 With rst=1 at a rising edge, the state SHALL go to RECV and acc, len, ovf, res_ok, res_ovf, res_len, cnt_ok and cnt_bad SHALL go to 0.
REQ-030 Outputs after reset: in_ready=1, res_valid=0.
REQ-031 Reset mid-frame or in DONE SHALL discard the partial frame or pending verdict without counting it.
REQ-032 rst has priority over a simultaneous beat or handshake.

Structure
REQ-033 Shared package checksum_pkg SHALL hold the default key constant (8'b00110111) and the state typedef {RECV, DONE}.
REQ-034 The comparison of in_data against acc XOR KEY SHALL be a combinational sub-module, checksum_cmp, parameterised by DATA_W and KEY.
REQ-035 The FSM, accumulator, length counter and statistics counters SHALL reside in checksum_stream.

Verification (DATA_W=8, KEY=8'h37, MAX_LEN=4)
REQ-036 Frame AA, then check 9D (last) -> res_valid one cycle later; res_ok=1, res_len=1, cnt_ok=1.
REQ-037 Frame AA, AD, AF, then check 9F -> res_ok=1, res_len=3; same frame with check 9E -> res_ok=0, cnt_bad=1.
REQ-038 Check word 37 alone -> res_ok=0, res_len=0.
REQ-039 Five payload words of 01, then check 36 -> res_ovf=1, res_ok=0, res_len=4.
REQ-040 Hold res_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0, verdict stable, no beats accepted; raising res_ready -> RECV the next cycle and counter updated.
REQ-041 Assert rst after 2 payload beats -> in_ready=1, counters 0; a following frame AA, 9D -> res_ok=1.
